// File: rtl/fixed_addsub_pkg.sv
// fixed_addsub_pkg: op encoding and error-counter width shared by fixed_addsub_pipe and its stages
package fixed_addsub_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int CNT_W = 16;
endpackage

// File: rtl/fixed_addsub_pipe_sat.sv
// fixed_sat_stage: overflow/underflow rule on the S1 result; saturates when FIXED_ADDSUB_SAT_EN is defined, wraps otherwise
module fixed_sat_stage
  import fixed_addsub_pkg::*;
#(
  parameter int INT_W = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    op,
  input  logic [INT_W+FRAC_W:0]   sum,
  output logic [INT_W+FRAC_W-1:0] res,
  output logic                    ovf,
  output logic                    unf
);
  localparam int W = INT_W + FRAC_W;
  // bit W is the carry-out for an add and the borrow (A<B) for a subtract
  always_comb begin
    ovf = (op == OP_ADD) && sum[W];
    unf = (op == OP_SUB) && sum[W];
`ifdef FIXED_ADDSUB_SAT_EN
    res = ovf ? '1 : unf ? '0 : sum[W-1:0];
`else
    res = sum[W-1:0];
`endif
  end
endmodule

// File: rtl/fixed_addsub_pipe.sv
// fixed_addsub_pipe: two-stage unsigned fixed-point add/sub with valid/ready and an error counter
// Build option FIXED_ADDSUB_SAT_EN selects saturating instead of wrapping results.
module fixed_addsub_pipe
  import fixed_addsub_pkg::*;
#(
  parameter int INT_W = 8,
  parameter int FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op,
  input  logic [INT_W-1:0]  a_int,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic [INT_W-1:0]  b_int,
  input  logic [FRAC_W-1:0] b_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INT_W-1:0]  res_int,
  output logic [FRAC_W-1:0] res_frac,
  output logic              ovf,
  output logic              unf,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int W = INT_W + FRAC_W;
  logic en, v1, op1, ovf_n, unf_n;
  logic [W:0] sum1;
  logic [W-1:0] res_n;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  fixed_sat_stage #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_sat (
    .op(op1), .sum(sum1), .res(res_n), .ovf(ovf_n), .unf(unf_n)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      op1 <= 1'b0;
      sum1 <= '0;
      out_valid <= 1'b0;
      {res_int, res_frac} <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      op1 <= op;
      sum1 <= (op == OP_SUB) ? {1'b0, a_int, a_frac} - {1'b0, b_int, b_frac}
                             : {1'b0, a_int, a_frac} + {1'b0, b_int, b_frac};
      out_valid <= v1;
      {res_int, res_frac} <= res_n;
      ovf <= ovf_n && v1;
      unf <= unf_n && v1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) err_cnt <= '0;
    else if (cnt_clr) err_cnt <= '0;
    else if (out_valid && out_ready && (ovf || unf) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// tb_fixed_addsub_pipe: directed vectors, backpressure/reset sequences and random traffic against a queue model
module tb_fixed_addsub_pipe;
  localparam int INT_W = 8, FRAC_W = 23, W = 31;
  typedef struct {
    logic o; logic [7:0] ai; logic [22:0] af; logic [7:0] bi; logic [22:0] bf;
    logic [7:0] ri; logic [22:0] rf; logic ov; logic un; int ec;
  } vec_t;
  typedef struct { logic [W-1:0] res; logic ov; logic un; } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, op = 0, out_ready = 1, cnt_clr = 0;
  logic in_ready, out_valid, ovf, unf;
  logic [7:0] a_int = 0, b_int = 0, res_int;
  logic [22:0] a_frac = 0, b_frac = 0, res_frac;
  logic [15:0] err_cnt;
  int checks = 0, errors = 0, exp_err = 0, delivered = 0;
  exp_t q[$];
  logic p_op = 0;
  logic [W-1:0] p_a = 0, p_b = 0, s_res = 0;
  logic held = 0, s_ov = 0, s_un = 0;
  vec_t tv[8];

  fixed_addsub_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_int(a_int), .a_frac(a_frac), .b_int(b_int), .b_frac(b_frac),
    .out_valid(out_valid), .out_ready(out_ready), .res_int(res_int), .res_frac(res_frac),
    .ovf(ovf), .unf(unf), .cnt_clr(cnt_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the real-valued operands scaled by 2^FRAC_W
  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint m, la, lb, r;
    m = longint'(1) << W;
    la = longint'(a);
    lb = longint'(b);
    e.ov = !o && (la + lb >= m);
    e.un = o && (la < lb);
    r = o ? la - lb : la + lb;
    if (r < 0) r += m;
    else if (r >= m) r -= m;
`ifdef FIXED_ADDSUB_SAT_EN
    if (e.ov) r = m - 1;
    if (e.un) r = 0;
`endif
    e.res = r[W-1:0];
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom % 5;
    return k == 0 ? '1 : k == 1 ? '0 : r[W-1:0];
  endfunction

  task automatic cycle(input logic iv, input logic orr, input logic clr, output logic acc);
    exp_t e;
    logic inc;
    @(posedge clk); #1;
    in_valid = iv; out_ready = orr; cnt_clr = clr; op = p_op;
    {a_int, a_frac} = p_a; {b_int, b_frac} = p_b;
    #1;
    chk("err_cnt", err_cnt, exp_err);
    if (held) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_res", {res_int, res_frac}, s_res);
      chk("hold_flags", {ovf, unf}, {s_ov, s_un});
    end
    inc = 0;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_beat: got out_valid=1 expected no beat in flight");
      end else begin
        e = q.pop_front();
        chk("res", {res_int, res_frac}, e.res);
        chk("ovf", ovf, e.ov);
        chk("unf", unf, e.un);
        inc = e.ov || e.un;
        delivered++;
      end
    end
    exp_err = clr ? 0 : (inc && exp_err != 16'hFFFF) ? exp_err + 1 : exp_err;
    held = out_valid && !out_ready;
    s_res = {res_int, res_frac}; s_ov = ovf; s_un = unf;
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(p_op, p_a, p_b));
  endtask

  initial begin
    logic acc;
    int k, d0;
`ifdef FIXED_ADDSUB_SAT_EN
    tv[2] = '{0, 8'd255, 23'h400000, 8'd1, 23'h0, 8'd255, 23'h7FFFFF, 1, 0, 1};
    tv[3] = '{1, 8'd1, 23'h0, 8'd2, 23'h0, 8'd0, 23'h0, 0, 1, 2};
    tv[6] = '{0, 8'd255, 23'h7FFFFF, 8'd0, 23'h1, 8'd255, 23'h7FFFFF, 1, 0, 3};
    tv[7] = '{1, 8'd0, 23'h0, 8'd0, 23'h1, 8'd0, 23'h0, 0, 1, 4};
`else
    tv[2] = '{0, 8'd255, 23'h400000, 8'd1, 23'h0, 8'd0, 23'h400000, 1, 0, 1};
    tv[3] = '{1, 8'd1, 23'h0, 8'd2, 23'h0, 8'd255, 23'h0, 0, 1, 2};
    tv[6] = '{0, 8'd255, 23'h7FFFFF, 8'd0, 23'h1, 8'd0, 23'h0, 1, 0, 3};
    tv[7] = '{1, 8'd0, 23'h0, 8'd0, 23'h1, 8'd255, 23'h7FFFFF, 0, 1, 4};
`endif
    tv[0] = '{0, 8'd3, 23'h400000, 8'd1, 23'h200000, 8'd4, 23'h600000, 0, 0, 0};
    tv[1] = '{0, 8'd0, 23'h600000, 8'd0, 23'h600000, 8'd1, 23'h400000, 0, 0, 0};
    tv[4] = '{1, 8'd5, 23'h100000, 8'd2, 23'h200000, 8'd2, 23'h700000, 0, 0, 2};
    tv[5] = '{1, 8'd7, 23'h000123, 8'd7, 23'h000123, 8'd0, 23'h0, 0, 0, 2};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res", {res_int, res_frac}, 0);
    chk("rst_flags", {ovf, unf}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      p_op = tv[i].o; p_a = {tv[i].ai, tv[i].af}; p_b = {tv[i].bi, tv[i].bf};
      cycle(1, 1, 0, acc);
      chk("vec_accept", acc, 1);
      cycle(0, 1, 0, acc);
      chk("vec_lat1_valid", out_valid, 0);
      cycle(0, 1, 0, acc);
      chk("vec_lat2_valid", out_valid, 1);
      chk("vec_res_int", res_int, tv[i].ri);
      chk("vec_res_frac", res_frac, tv[i].rf);
      chk("vec_flags", {ovf, unf}, {tv[i].ov, tv[i].un});
      cycle(0, 1, 0, acc);
      chk("vec_err_cnt", err_cnt, tv[i].ec);
    end
    // backpressure: stall with continuous input, then release and drain 8 beats in order
    k = 0; d0 = delivered;
    p_op = 0; p_a = {8'd1, 23'h1}; p_b = {8'd0, 23'h0};
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, acc);
      if (acc) begin k++; p_a = {8'(k + 1), 23'(k)}; p_b = {8'(k), 23'h1}; end
    end
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_accepted_while_stalled", k, 2);
    for (int i = 0; i < 40 && !(k == 8 && q.size() == 0); i++) begin
      cycle(k < 8, 1, 0, acc);
      if (acc) begin k++; p_a = {8'(k + 1), 23'(k)}; p_b = {8'(k), 23'h1}; end
    end
    chk("bp_delivered", delivered - d0, 8);
    // reset with both stages full discards them; err_cnt is nonzero from the vectors
    p_a = {8'd9, 23'h0}; p_b = {8'd4, 23'h0};
    cycle(1, 0, 0, acc);
    cycle(1, 0, 0, acc);
    @(posedge clk); #1;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    in_valid = 0;
    @(posedge clk); #1;
    chk("rst_edge_valid", out_valid, 0);
    chk("rst_edge_in_ready", in_ready, 1);
    rst = 0;
    q.delete(); held = 0; exp_err = 0;
    p_op = 0; p_a = {8'd255, 23'h400000}; p_b = {8'd1, 23'h0};
    cycle(1, 0, 0, acc);
    chk("post_rst_accept", acc, 1);
    cycle(0, 0, 0, acc);
    cycle(0, 0, 0, acc);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_ovf", ovf, 1);
    cycle(0, 1, 1, acc);
    cycle(0, 1, 0, acc);
    chk("clr_wins_err_cnt", err_cnt, 0);
    chk("post_clr_drained", q.size(), 0);
    for (int i = 0; i < 1500; i++) begin
      if (q.size() == 0 || acc) begin p_op = 1'($urandom); p_a = pick(); p_b = pick(); end
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 64) == 0, acc);
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(0, 1, 0, acc);
    chk("final_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
